// File: rtl/fft_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: walks stages and butterflies,
// moves operands RAM -> butterfly -> RAM, and aborts if the butterfly never answers.
module fft_sequencer #(
  parameter int LOG2N   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  input  logic [63:0]      rd_data_a,
  input  logic [63:0]      rd_data_b,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic [63:0]      wr_data,
  output logic [31:0]      r1,
  output logic [31:0]      i1,
  output logic [31:0]      r2,
  output logic [31:0]      i2,
  output logic [6:0]       r,
  output logic             start,
  input  logic             ready,
  input  logic             valid,
  input  logic [31:0]      newr1,
  input  logic [31:0]      newi1,
  input  logic [31:0]      newr2,
  input  logic [31:0]      newi2
);

  localparam logic [LOG2N-1:0] K_LAST = LOG2N'((1 << (LOG2N - 1)) - 1);
  localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT_RD, START, WAIT_BF, WR_A, WR_B, DONE} state_t;

  state_t           state;
  logic [3:0]       stage;
  logic [LOG2N-1:0] k;
  logic [7:0]       tmo_cnt;
  logic [31:0]      res_r2;
  logic [31:0]      res_i2;
  logic [3:0]       stage_next;
  logic [LOG2N-1:0] k_next;
  logic             last_bfly;

  function automatic logic [LOG2N-1:0] low_mask(input logic [3:0] s);
    return (LOG2N'(1) << s) - LOG2N'(1);
  endfunction

  function automatic logic [LOG2N-1:0] addr_top(input logic [3:0] s, input logic [LOG2N-1:0] kk);
    return ((kk >> s) << (s + 4'd1)) | (kk & low_mask(s));
  endfunction

  function automatic logic [LOG2N-1:0] addr_bot(input logic [3:0] s, input logic [LOG2N-1:0] kk);
    return addr_top(s, kk) | (LOG2N'(1) << s);
  endfunction

  function automatic logic [6:0] twiddle(input logic [3:0] s, input logic [LOG2N-1:0] kk);
    return 7'(kk & low_mask(s)) << (S_LAST - s);
  endfunction

  always_comb begin
    k_next     = k + LOG2N'(1);
    stage_next = stage;
    if (k == K_LAST) begin
      k_next     = '0;
      stage_next = stage + 4'd1;
    end
    last_bfly = (k == K_LAST) && (stage == S_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      tmo_cnt   <= '0;
      res_r2    <= '0;
      res_i2    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      r1        <= '0;
      i1        <= '0;
      r2        <= '0;
      i2        <= '0;
      r         <= '0;
      start     <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            err       <= 1'b0;
            busy      <= 1'b1;
            stage     <= '0;
            k         <= '0;
            rd_en     <= 1'b1;
            rd_addr_a <= addr_top(4'd0, '0);
            rd_addr_b <= addr_bot(4'd0, '0);
            state     <= READ;
          end
        end
        READ: state <= WAIT_RD;
        WAIT_RD: begin
          r1    <= rd_data_a[63:32];
          i1    <= rd_data_a[31:0];
          r2    <= rd_data_b[63:32];
          i2    <= rd_data_b[31:0];
          state <= START;
          if (ready) begin
            start <= 1'b1;
            r     <= twiddle(stage, k);
          end
        end
        // start is raised for exactly the one START cycle in which the pulse is visible
        START: begin
          if (start) begin
            tmo_cnt <= '0;
            state   <= WAIT_BF;
          end else if (ready) begin
            start <= 1'b1;
            r     <= twiddle(stage, k);
          end
        end
        WAIT_BF: begin
          if (valid) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_top(stage, k);
            wr_data <= {newr1, newi1};
            res_r2  <= newr2;
            res_i2  <= newi2;
            state   <= WR_A;
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WR_A: begin
          wr_en   <= 1'b1;
          wr_addr <= addr_bot(stage, k);
          wr_data <= {res_r2, res_i2};
          state   <= WR_B;
        end
        WR_B: begin
          if (last_bfly) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            stage     <= stage_next;
            k         <= k_next;
            rd_en     <= 1'b1;
            rd_addr_a <= addr_top(stage_next, k_next);
            rd_addr_b <= addr_bot(stage_next, k_next);
            state     <= READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer (N=8): RAM model, floating-point butterfly stub and a
// scoreboard of expected read pairs, twiddles, operands and write-backs.
module tb_fft_sequencer;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic             busy, done, err, rd_en, wr_en, start;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [63:0]      rd_data_a = '0;
  logic [63:0]      rd_data_b = '0;
  logic [63:0]      wr_data;
  logic [31:0]      r1, i1, r2, i2;
  logic [6:0]       r;
  logic             ready;
  logic             valid = 1'b0;
  logic [31:0]      newr1 = '0, newi1 = '0, newr2 = '0, newi2 = '0;

  always #5 clk = ~clk;

  fft_sequencer #(.LOG2N(LOG2N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .r1(r1), .i1(i1), .r2(r2), .i2(i2), .r(r), .start(start),
    .ready(ready), .valid(valid),
    .newr1(newr1), .newi1(newi1), .newr2(newr2), .newi2(newi2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Expected address trace for N=8, one entry per butterfly in execution order
  int tab_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tab_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tab_r[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  logic [LOG2N-1:0] rdq_a[$], rdq_b[$], waq[$];
  logic [6:0]       rq[$];
  logic [127:0]     opq[$];
  logic [63:0]      wdq[$];

  // ---------------- float helpers and butterfly model ----------------
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic sgn;
    int   e, mant;
    real  m;
    if (x < 1.0e-30 && x > -1.0e-30) return 32'd0;
    sgn = (x < 0.0);
    m   = sgn ? -x : x;
    e   = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    mant = int'((m - 1.0) * 8388608.0);
    if (mant >= 8388608) begin mant = 0; e++; end
    return {sgn, 8'(e + 127), mant[22:0]};
  endfunction

  function automatic logic [127:0] bfly(input logic [63:0] a, input logic [63:0] b, input logic [6:0] rr);
    real ar, ai, br, bi, wr, wi, tr, ti, ang;
    ar  = f2r(a[63:32]);
    ai  = f2r(a[31:0]);
    br  = f2r(b[63:32]);
    bi  = f2r(b[31:0]);
    ang = 2.0 * 3.14159265358979 * real'(rr) / real'(N);
    wr  = $cos(ang);
    wi  = -$sin(ang);
    tr  = br * wr - bi * wi;
    ti  = br * wi + bi * wr;
    return {r2f(ar + tr), r2f(ai + ti), r2f(ar - tr), r2f(ai - ti)};
  endfunction

  // ---------------- RAM model: read data valid the cycle after rd_en ----------------
  logic [63:0] mem [N];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // ---------------- butterfly stub: valid L cycles after the start cycle ----------------
  bit           no_valid   = 1'b0;
  bit           hold_ready = 1'b0;
  bit           rand_lat   = 1'b0;
  int           lat_l      = 4;
  int           cur_l      = 4;
  int           bf_cnt     = 0;
  int           rdy_cnt    = 0;
  longint       lat_sum    = 0;
  logic [127:0] bf_res     = '0;
  logic [127:0] bf_now;

  assign bf_now = bfly({r1, i1}, {r2, i2}, r);
  assign ready  = (rdy_cnt == 0);

  always @(posedge clk) begin
    valid <= 1'b0;
    if (rst) begin
      bf_cnt  <= 0;
      rdy_cnt <= 0;
    end else begin
      if (hold_ready && rd_en) rdy_cnt <= 7;
      else if (rdy_cnt != 0)   rdy_cnt <= rdy_cnt - 1;
      if (rd_en) cur_l <= rand_lat ? int'($urandom_range(1, 10)) : lat_l;
      if (start && !no_valid) begin
        lat_sum <= lat_sum + longint'(cur_l);
        if (cur_l == 1) begin
          valid <= 1'b1;
          {newr1, newi1, newr2, newi2} <= bf_now;
          wdq.push_back(bf_now[127:64]);
          wdq.push_back(bf_now[63:0]);
        end else begin
          bf_res <= bf_now;
          bf_cnt <= cur_l - 1;
        end
      end else if (bf_cnt != 0) begin
        if (bf_cnt == 1) begin
          valid <= 1'b1;
          {newr1, newi1, newr2, newi2} <= bf_res;
          wdq.push_back(bf_res[127:64]);
          wdq.push_back(bf_res[63:0]);
        end
        bf_cnt <= bf_cnt - 1;
      end
    end
  end

  // ---------------- monitor: pops the scoreboard on every DUT transaction ----------------
  int   n_start = 0, n_wr = 0, n_done = 0, n_excl = 0, n_dbl = 0, n_extra = 0;
  logic start_q = 1'b0;

  initial begin
    logic [127:0] op;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ((int'(rd_en) + int'(wr_en) + int'(start)) > 1) n_excl++;
        if (start && start_q) n_dbl++;
        if (rd_en) begin
          if (rdq_a.size() == 0) n_extra++;
          else begin
            check("rd_addr_a", 64'(rd_addr_a), 64'(rdq_a.pop_front()));
            check("rd_addr_b", 64'(rd_addr_b), 64'(rdq_b.pop_front()));
            opq.push_back({mem[rd_addr_a], mem[rd_addr_b]});
          end
        end
        if (start) begin
          n_start++;
          if (rq.size() == 0 || opq.size() == 0) n_extra++;
          else begin
            op = opq.pop_front();
            check("twiddle_r", 64'(r), 64'(rq.pop_front()));
            check("operand_a", {r1, i1}, op[127:64]);
            check("operand_b", {r2, i2}, op[63:0]);
          end
        end
        if (wr_en) begin
          n_wr++;
          if (waq.size() == 0 || wdq.size() == 0) n_extra++;
          else begin
            check("wr_addr", 64'(wr_addr), 64'(waq.pop_front()));
            check("wr_data", wr_data, wdq.pop_front());
          end
        end
        if (done) n_done++;
      end
      start_q = start;
    end
  end

  // ---------------- stimulus ----------------
  task automatic flush();
    rdq_a.delete(); rdq_b.delete(); waq.delete(); rq.delete(); opq.delete(); wdq.delete();
  endtask

  task automatic push_expect();
    for (int i = 0; i < 12; i++) begin
      rdq_a.push_back(LOG2N'(tab_a[i]));
      rdq_b.push_back(LOG2N'(tab_b[i]));
      rq.push_back(7'(tab_r[i]));
      waq.push_back(LOG2N'(tab_a[i]));
      waq.push_back(LOG2N'(tab_b[i]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, done, err, rd_en, wr_en, start, r, rd_addr_a, rd_addr_b, wr_addr}), 64'd0);
    check({tag, "_wr_data"}, wr_data, 64'd0);
    check({tag, "_op_a"}, {r1, i1}, 64'd0);
    check({tag, "_op_b"}, {r2, i2}, 64'd0);
  endtask

  // Called just after a rising edge; returns cycles from go to the done pulse
  task automatic run_fft(input string name, input bit go_again, output int cycles);
    int w0;
    w0 = n_wr;
    push_expect();
    go = 1'b1;
    cycles = 0;
    while (cycles < 3000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == 1) begin
        go = 1'b0;
        check({name, "_busy_after_go"}, 64'(busy), 64'd1);
        check({name, "_err_cleared"}, 64'(err), 64'd0);
      end
      if (go_again) go = (cycles == 10);
      if (done) break;
    end
    if (!done) check({name, "_done_seen"}, 64'(done), 64'd1);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 64'({done, busy}), 64'd0);
    check({name, "_writes"}, 64'(n_wr - w0), 64'd24);
    check({name, "_queues_empty"}, 64'(rdq_a.size() + waq.size() + wdq.size() + rq.size()), 64'd0);
    $display("run %s: done after %0d cycles, %0d writes", name, cycles, n_wr - w0);
  endtask

  initial begin
    int     cyc, w0, d0, s0;
    longint ls0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: address trace, twiddles and done timing with L=4
    for (int i = 0; i < N; i++) mem[i] = {r2f(real'(i + 1)), r2f(-real'(i))};
    run_fft("t1_trace", 1'b0, cyc);
    check("t1_done_cycles", 64'(cyc), 64'(12 * (5 + 4) + 1));

    // Test 2: impulse in, flat spectrum out
    for (int i = 0; i < N; i++) mem[i] = 64'd0;
    mem[0] = 64'h3F800000_00000000;
    run_fft("t2_impulse", 1'b0, cyc);
    for (int i = 0; i < N; i++) check("t2_ram_word", mem[i], 64'h3F800000_00000000);

    // Test 3: go pulsed mid-run is ignored
    s0 = n_start;
    run_fft("t3_go_busy", 1'b1, cyc);
    check("t3_done_cycles", 64'(cyc), 64'(12 * (5 + 4) + 1));
    check("t3_starts", 64'(n_start - s0), 64'd12);

    // Test 4: butterfly never answers -> timeout abort
    no_valid = 1'b1;
    flush();
    w0 = n_wr;
    d0 = n_done;
    push_expect();
    go = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) go = 1'b0;
      if (!busy) break;
    end
    check("t4_abort_cycles", 64'(cyc), 64'd24);
    check("t4_err", 64'(err), 64'd1);
    check("t4_no_writes", 64'(n_wr - w0), 64'd0);
    check("t4_no_done", 64'(n_done - d0), 64'd0);
    $display("run t4_timeout: aborted after %0d cycles, err=%0b", cyc, err);
    no_valid = 1'b0;
    flush();
    run_fft("t4_recover", 1'b0, cyc);
    check("t4_recover_cycles", 64'(cyc), 64'(12 * (5 + 4) + 1));

    // Test 5: reset during WAIT_BF of stage 1
    flush();
    s0 = n_start;
    push_expect();
    go = 1'b1;
    cyc = 0;
    while (cyc < 500) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) go = 1'b0;
      if (n_start - s0 >= 5) break;
    end
    w0 = n_wr;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("t5_rst");
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_write_after_rst", 64'(n_wr - w0), 64'd0);
    check("t5_idle", 64'({busy, done, err}), 64'd0);
    $display("run t5_reset: reset applied after %0d cycles", cyc);
    flush();
    run_fft("t5_restart", 1'b0, cyc);
    check("t5_restart_cycles", 64'(cyc), 64'(12 * (5 + 4) + 1));

    // Test 6: ready held low 7 cycles per butterfly, random latency 1..10
    hold_ready = 1'b1;
    rand_lat   = 1'b1;
    flush();
    ls0 = lat_sum;
    s0  = n_start;
    run_fft("t6_stall", 1'b0, cyc);
    check("t6_done_cycles", 64'(cyc), 64'(12 * (5 + 7) + int'(lat_sum - ls0) + 1));
    check("t6_starts", 64'(n_start - s0), 64'd12);
    hold_ready = 1'b0;
    rand_lat   = 1'b0;

    check("strobe_exclusive", 64'(n_excl), 64'd0);
    check("start_single_pulse", 64'(n_dbl), 64'd0);
    check("unexpected_txn", 64'(n_extra), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
